hazard_fwd_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's fixed EX/MEM hazard logic.
- Tracks in-flight register writers across NUM_STAGES downstream pipeline stages, stage 1 being EX.
- Generates per-operand forwarding selects, load-use stalls with configurable load latency, global freeze from memory back-pressure, and IF flush on taken control transfer.
- Sits beside the ID stage; the datapath muxes and the PC/IF-ID enables consume its outputs.

---
 rtl/hazard_fwd_scoreboard_pkg.sv | 20 ++
 rtl/hazard_fwd_scoreboard_if.sv | 42 ++++
 rtl/hazard_fwd_scoreboard_resolve.sv | 41 ++++
 rtl/hazard_fwd_scoreboard.sv | 87 ++++++++
 tb/tb_hazard_fwd_scoreboard.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_scoreboard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
// The entry type is sized for the widest register index supported so that
// it can stay a plain package typedef; narrower indices are zero-extended.
package hazard_pkg;

   localparam int FWD_RF    = 0;
   localparam int HZ_MAX_AW = 8;

   typedef struct packed {
      logic                 valid;
      logic                 wreg;
      logic [HZ_MAX_AW-1:0] dst;
      logic                 is_load;
   } hz_entry_t;

   function automatic int fwd_sel_w(input int numStages);
      return $clog2(numStages + 1);
   endfunction

endpackage

// File: rtl/hazard_fwd_scoreboard_if.sv
// ID-stage side bundle of the scoreboard: decoded operand info in,
// forwarding selects and pipeline control out.
interface hazard_fwd_scoreboard_if
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_STAGES = 3,
   parameter int CNT_W      = 16,
   parameter int FW         = fwd_sel_w(NUM_STAGES)
) ();

   logic              id_valid;
   logic [REG_AW-1:0] id_rs;
   logic [REG_AW-1:0] id_rt;
   logic              id_use_rs;
   logic              id_use_rt;
   logic [REG_AW-1:0] id_dst;
   logic              id_wreg;
   logic              id_is_load;
   logic              id_redirect;
   logic              mem_busy;

   logic [FW-1:0]     fwd_a;
   logic [FW-1:0]     fwd_b;
   logic              stall;
   logic              bubble;
   logic              flush_if;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
             id_wreg, id_is_load, id_redirect, mem_busy,
      input  fwd_a, fwd_b, stall, bubble, flush_if, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
             id_wreg, id_is_load, id_redirect, mem_busy,
      output fwd_a, fwd_b, stall, bubble, flush_if, stall_cnt
   );

endinterface

// File: rtl/hazard_fwd_scoreboard_resolve.sv
// Per-operand priority search over the in-flight writers. The youngest
// matching stage decides: forward from it if its data is ready, otherwise
// report a hazard and fall back to the register file.
module hazard_src_resolve
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_STAGES = 3,
   parameter int LOAD_LAT   = 1,
   parameter int FW         = fwd_sel_w(NUM_STAGES)
) (
   input  hz_entry_t [NUM_STAGES:1] i_entries,
   input  logic [REG_AW-1:0]        i_reg,
   input  logic                     i_use,
   output logic [FW-1:0]            o_sel,
   output logic                     o_hazard
);

   logic w_found;

   // Scan from stage 1 upward so the first hit is the youngest writer.
   always_comb begin
      o_sel    = FW'(FWD_RF);
      o_hazard = 1'b0;
      w_found  = 1'b0;
      if (i_use && (i_reg != '0)) begin
         for (int k = 1; k <= NUM_STAGES; k++) begin
            if (!w_found && i_entries[k].valid && i_entries[k].wreg &&
                (i_entries[k].dst == HZ_MAX_AW'(i_reg))) begin
               w_found = 1'b1;
               if (!i_entries[k].is_load || (k >= 1 + LOAD_LAT)) begin
                  o_sel = FW'(k);
               end else begin
                  o_hazard = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_scoreboard.sv
// Hazard and forwarding scoreboard beside the ID stage. Keeps a shift
// register of destination info for every stage after ID, resolves both
// source operands against it and drives stall/bubble/flush control.
module hazard_fwd_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_STAGES = 3,
   parameter int LOAD_LAT   = 1,
   parameter int CNT_W      = 16
) (
   input logic                   clk,
   input logic                   rst,
   hazard_fwd_scoreboard_if.slave bus
);

   localparam int FW = fwd_sel_w(NUM_STAGES);

   hz_entry_t [NUM_STAGES:1] r_entries;
   logic [CNT_W-1:0]         r_stallCnt;

   logic [FW-1:0] w_selA;
   logic [FW-1:0] w_selB;
   logic          w_hazA;
   logic          w_hazB;
   logic          w_loadHz;
   logic          w_stall;
   logic          w_bubble;
   hz_entry_t     w_newEntry;

   hazard_src_resolve #(
      .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .FW(FW)
   ) u_resolveA (
      .i_entries(r_entries),
      .i_reg    (bus.id_rs),
      .i_use    (bus.id_use_rs),
      .o_sel    (w_selA),
      .o_hazard (w_hazA)
   );

   hazard_src_resolve #(
      .REG_AW(REG_AW), .NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .FW(FW)
   ) u_resolveB (
      .i_entries(r_entries),
      .i_reg    (bus.id_rt),
      .i_use    (bus.id_use_rt),
      .o_sel    (w_selB),
      .o_hazard (w_hazB)
   );

   // Combine operand hazards with back-pressure; a frozen pipeline never
   // takes a bubble, and everything is quiet when ID holds no instruction.
   always_comb begin
      w_loadHz   = bus.id_valid & (w_hazA | w_hazB);
      w_stall    = bus.id_valid & (w_loadHz | bus.mem_busy);
      w_bubble   = w_loadHz & ~bus.mem_busy;
      w_newEntry = '0;
      if (!w_bubble) begin
         w_newEntry.valid   = bus.id_valid;
         w_newEntry.wreg    = bus.id_wreg;
         w_newEntry.dst     = HZ_MAX_AW'(bus.id_dst);
         w_newEntry.is_load = bus.id_is_load;
      end
   end

   assign bus.fwd_a     = bus.id_valid ? w_selA : FW'(FWD_RF);
   assign bus.fwd_b     = bus.id_valid ? w_selB : FW'(FWD_RF);
   assign bus.stall     = w_stall;
   assign bus.bubble    = w_bubble;
   assign bus.flush_if  = bus.id_valid & bus.id_redirect & ~w_stall;
   assign bus.stall_cnt = r_stallCnt;

   // Advance the writer history one stage per unfrozen cycle; the oldest
   // entry falls off the end because WB forwarding already covers it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_entries  <= '0;
         r_stallCnt <= '0;
      end else if (!bus.mem_busy) begin
         r_entries <= {r_entries[NUM_STAGES-1:1], w_newEntry};
         if (w_bubble && (r_stallCnt != '1)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_fwd_scoreboard.sv
// Bench for the hazard/forwarding scoreboard. Two instances share one
// stimulus stream: the default configuration (3 stages, load latency 1)
// and a deeper one (4 stages, load latency 2).
module tb_hazard_fwd_scoreboard;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   hazard_fwd_scoreboard_if #(.REG_AW(5), .NUM_STAGES(3), .CNT_W(16)) ifA ();
   hazard_fwd_scoreboard_if #(.REG_AW(5), .NUM_STAGES(4), .CNT_W(16)) ifB ();

   hazard_fwd_scoreboard #(.REG_AW(5), .NUM_STAGES(3), .LOAD_LAT(1), .CNT_W(16)) dutA (
      .clk(clk), .rst(rst), .bus(ifA)
   );

   hazard_fwd_scoreboard #(.REG_AW(5), .NUM_STAGES(4), .LOAD_LAT(2), .CNT_W(16)) dutB (
      .clk(clk), .rst(rst), .bus(ifB)
   );

   typedef struct {
      string      name;
      logic       valid;
      logic [4:0] rs;
      logic       useRs;
      logic [4:0] rt;
      logic       useRt;
      logic [4:0] dst;
      logic       wreg;
      logic       isLoad;
      logic       redirect;
      logic       memBusy;
      int         expFwdA;
      int         expFwdB;
      logic       expStall;
      logic       expBubble;
      logic       expFlush;
   } vec_t;

   vec_t tbl[$];
   vec_t expQ[$];

   // Build one vector record from a compact argument list.
   function automatic vec_t mk(input string n, input bit v, input int rs, input bit ur,
                               input int rt, input bit ut, input int dst, input bit w,
                               input bit ld, input bit br, input bit mb, input int fa,
                               input int fb, input bit st, input bit bu, input bit fl);
      vec_t r;
      r.name = n;       r.valid = v;      r.rs = 5'(rs);     r.useRs = ur;
      r.rt = 5'(rt);    r.useRt = ut;     r.dst = 5'(dst);   r.wreg = w;
      r.isLoad = ld;    r.redirect = br;  r.memBusy = mb;
      r.expFwdA = fa;   r.expFwdB = fb;   r.expStall = st;
      r.expBubble = bu; r.expFlush = fl;
      return r;
   endfunction

   // Single comparison with pass/fail bookkeeping.
   task automatic checkVal(input string name, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
      end
   endtask

   // Drive the same ID-stage inputs into both instances.
   task automatic setInputs(input vec_t v);
      ifA.id_valid = v.valid;   ifB.id_valid = v.valid;
      ifA.id_rs = v.rs;         ifB.id_rs = v.rs;
      ifA.id_use_rs = v.useRs;  ifB.id_use_rs = v.useRs;
      ifA.id_rt = v.rt;         ifB.id_rt = v.rt;
      ifA.id_use_rt = v.useRt;  ifB.id_use_rt = v.useRt;
      ifA.id_dst = v.dst;       ifB.id_dst = v.dst;
      ifA.id_wreg = v.wreg;     ifB.id_wreg = v.wreg;
      ifA.id_is_load = v.isLoad; ifB.id_is_load = v.isLoad;
      ifA.id_redirect = v.redirect; ifB.id_redirect = v.redirect;
      ifA.mem_busy = v.memBusy; ifB.mem_busy = v.memBusy;
   endtask

   task automatic applyStimulus(input vec_t v);
      setInputs(v);
      expQ.push_back(v);
   endtask

   // Sample instance A mid-cycle against the oldest queued expectation,
   // then move to just after the next rising edge.
   task automatic checkOutput();
      vec_t e;
      @(negedge clk);
      if (expQ.size() == 0) begin
         checkCount++;
         failCount++;
         $display("[TB] FAIL scoreboard_empty actual=0 expected=1");
      end else begin
         e = expQ.pop_front();
         checkVal({e.name, ".fwd_a"},    int'(ifA.fwd_a),    e.expFwdA);
         checkVal({e.name, ".fwd_b"},    int'(ifA.fwd_b),    e.expFwdB);
         checkVal({e.name, ".stall"},    int'(ifA.stall),    int'(e.expStall));
         checkVal({e.name, ".bubble"},   int'(ifA.bubble),   int'(e.expBubble));
         checkVal({e.name, ".flush_if"}, int'(ifA.flush_if), int'(e.expFlush));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      setInputs(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      vec_t v;

      //           name            v  rs ur rt ut dst w ld br mb  fa fb st bu fl
      tbl.push_back(mk("reset_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("alu_w5",      1, 1, 1, 2, 1, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("read_r5_s1",  1, 5, 1, 6, 1, 9, 1, 0, 0, 0,  1, 0, 0, 0, 0));
      tbl.push_back(mk("read_r5_s2",  1, 5, 1, 9, 1, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0));
      tbl.push_back(mk("read_r5_wb",  1, 5, 1, 9, 1, 0, 0, 0, 0, 0,  3, 2, 0, 0, 0));
      tbl.push_back(mk("use_off",     1, 9, 0, 9, 1, 0, 0, 0, 0, 0,  0, 3, 0, 0, 0));
      tbl.push_back(mk("load_r8",     1, 0, 0, 0, 0, 8, 1, 1, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("use_r8_stall",1, 0, 0, 8, 1,10, 1, 0, 0, 0,  0, 0, 1, 1, 0));
      tbl.push_back(mk("use_r8_fwd",  1, 0, 0, 8, 1,10, 1, 0, 0, 0,  0, 2, 0, 0, 0));
      tbl.push_back(mk("w7_old",      1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("w7_young",    1, 0, 0, 0, 0, 7, 1, 0, 0, 0,  0, 0, 0, 0, 0));
      tbl.push_back(mk("r7_youngest", 1, 7, 1, 0, 1, 0, 1, 0, 0, 0,  1, 0, 0, 0, 0));
      tbl.push_back(mk("r0_never",    1, 0, 1, 7, 1, 0, 0, 0, 0, 0,  0, 2, 0, 0, 0));
      tbl.push_back(mk("branch_nohz", 1, 7, 1, 0, 0, 0, 0, 0, 1, 0,  3, 0, 0, 0, 1));
      tbl.push_back(mk("invalid_br",  0, 7, 1, 0, 0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0));

      setInputs(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      checkVal("in_reset.stall_cnt_a", int'(ifA.stall_cnt), 0);
      checkVal("in_reset.stall_a",     int'(ifA.stall),     0);
      doReset();

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput();
      end
      checkVal("table.stall_cnt_a", int'(ifA.stall_cnt), 1);
      checkVal("table.stall_cnt_b", int'(ifB.stall_cnt), 2);

      // Deep configuration: a load needs two stall cycles before forwarding.
      doReset();
      setInputs(mk("ld_r3", 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      nextCycle();
      v = mk("use_r3", 1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      setInputs(v);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checkVal($sformatf("lat2_c%0d.stall_b", c),  int'(ifB.stall),  1);
         checkVal($sformatf("lat2_c%0d.bubble_b", c), int'(ifB.bubble), 1);
         checkVal($sformatf("lat2_c%0d.fwd_a_b", c),  int'(ifB.fwd_a),  0);
         nextCycle();
      end
      @(negedge clk);
      checkVal("lat2_done.stall_b", int'(ifB.stall), 0);
      checkVal("lat2_done.fwd_a_b", int'(ifB.fwd_a), 3);
      checkVal("lat2_done.cnt_b",   int'(ifB.stall_cnt), 2);
      nextCycle();

      // Back-pressure during a load-use stall: freeze, then exactly one bubble.
      doReset();
      setInputs(mk("ld_r8", 1, 0, 0, 0, 0, 8, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      nextCycle();
      v = mk("use_r8", 1, 0, 0, 8, 1, 11, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      setInputs(v);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checkVal($sformatf("busy_c%0d.stall", c),  int'(ifA.stall),  1);
         checkVal($sformatf("busy_c%0d.bubble", c), int'(ifA.bubble), 0);
         nextCycle();
      end
      checkVal("busy_release.cnt_before", int'(ifA.stall_cnt), 0);
      v.memBusy = 1'b0;
      setInputs(v);
      @(negedge clk);
      checkVal("busy_release.stall",  int'(ifA.stall),  1);
      checkVal("busy_release.bubble", int'(ifA.bubble), 1);
      nextCycle();
      @(negedge clk);
      checkVal("busy_after.stall", int'(ifA.stall), 0);
      checkVal("busy_after.fwd_b", int'(ifA.fwd_b), 2);
      checkVal("busy_after.cnt",   int'(ifA.stall_cnt), 1);
      nextCycle();

      // Taken branch waiting on a load: flush only once the stall clears.
      doReset();
      setInputs(mk("ld_r4", 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      nextCycle();
      setInputs(mk("br_r4", 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkVal("br_hz.stall",    int'(ifA.stall),    1);
      checkVal("br_hz.flush_if", int'(ifA.flush_if), 0);
      nextCycle();
      @(negedge clk);
      checkVal("br_go.stall",    int'(ifA.stall),    0);
      checkVal("br_go.flush_if", int'(ifA.flush_if), 1);
      checkVal("br_go.fwd_a",    int'(ifA.fwd_a),    2);
      nextCycle();

      // Reset asserted in the middle of a load-use stall.
      setInputs(mk("ld_r4b", 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      nextCycle();
      setInputs(mk("use_r4b", 1, 4, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      checkVal("pre_rst.stall", int'(ifA.stall),     1);
      checkVal("pre_rst.cnt",   int'(ifA.stall_cnt), 1);
      rst = 1'b1;
      #1;
      checkVal("mid_rst.stall",  int'(ifA.stall),     0);
      checkVal("mid_rst.bubble", int'(ifA.bubble),    0);
      checkVal("mid_rst.cnt",    int'(ifA.stall_cnt), 0);
      #1;
      rst = 1'b0;
      setInputs(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      nextCycle();

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
